// File: rtl/user_axi_dma_pkg.sv
// Shared response codes, FSM state types and width helper for the user_axi_dma memory responder.
package user_axi_dma_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_BURST} rd_state_t;

  function automatic int bytes_log2(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/user_axi_dma_mem_ram.sv
// Simple dual-port RAM: byte-masked write port, registered read port (1-cycle latency, read-first).
module user_axi_dma_mem_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDR_BITS-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    mem_en,
  input  logic [ADDR_BITS-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (mem_en) rd_data_q <= mem[rd_addr];
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (wr_en && wr_strb[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/user_axi_dma_mem_responder.sv
// AXI4 INCR-burst memory responder with independent write (AW/W/B) and read (AR/R) channel FSMs.
module user_axi_dma_mem_responder
  import user_axi_dma_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 128,
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    MEM_WORDS_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                    user_axi_clk,
  input  logic                    user_axi_rst,
  input  logic [ADDR_WIDTH-1:0]   user_axi_dma_awaddr,
  input  logic [7:0]              user_axi_dma_awlen,
  input  logic [2:0]              user_axi_dma_awsize,
  input  logic                    user_axi_dma_awvalid,
  output logic                    user_axi_dma_awready,
  input  logic [DATA_WIDTH-1:0]   user_axi_dma_wdata,
  input  logic [DATA_WIDTH/8-1:0] user_axi_dma_wstrb,
  input  logic                    user_axi_dma_wlast,
  input  logic                    user_axi_dma_wvalid,
  output logic                    user_axi_dma_wready,
  output logic [1:0]              user_axi_dma_bresp,
  output logic                    user_axi_dma_bvalid,
  input  logic                    user_axi_dma_bready,
  input  logic [ADDR_WIDTH-1:0]   user_axi_dma_araddr,
  input  logic [7:0]              user_axi_dma_arlen,
  input  logic [2:0]              user_axi_dma_arsize,
  input  logic                    user_axi_dma_arvalid,
  output logic                    user_axi_dma_arready,
  output logic [DATA_WIDTH-1:0]   user_axi_dma_rdata,
  output logic [1:0]              user_axi_dma_rresp,
  output logic                    user_axi_dma_rlast,
  output logic                    user_axi_dma_rvalid,
  input  logic                    user_axi_dma_rready
);

  localparam int         LOG2B    = bytes_log2(DATA_WIDTH);
  localparam int         WIN_LOG2 = LOG2B + MEM_WORDS_LOG2;
  localparam logic [2:0] SIZE_OK  = 3'(LOG2B);

  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr < BASE_ADDR) || ((off >> WIN_LOG2) != '0) || (size != SIZE_OK);
  endfunction

  function automatic logic [MEM_WORDS_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return MEM_WORDS_LOG2'((addr - BASE_ADDR) >> LOG2B);
  endfunction

  wr_state_t                 wr_state_q, wr_state_d;
  logic [MEM_WORDS_LOG2-1:0] wr_idx_q, wr_idx_d;
  logic [8:0]                wr_cnt_q, wr_cnt_d;
  logic                      wr_err_q, wr_err_d, wr_last_err_q, wr_last_err_d;
  logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;

  rd_state_t                 rd_state_q, rd_state_d;
  logic [MEM_WORDS_LOG2-1:0] rd_idx_q, rd_idx_d;
  logic [8:0]                rd_rem_q, rd_rem_d;
  logic                      rd_err_q, rd_err_d, fetch_q, fetch_d, fetch_last_q, fetch_last_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d, ram_rd_data;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, can_load, mem_en;

  assign aw_hs    = user_axi_dma_awvalid && awready_q;
  assign w_hs     = user_axi_dma_wvalid && wready_q;
  assign b_hs     = bvalid_q && user_axi_dma_bready;
  assign ar_hs    = user_axi_dma_arvalid && arready_q;
  assign r_hs     = rvalid_q && user_axi_dma_rready;
  assign can_load = !rvalid_q || user_axi_dma_rready;
  assign mem_en   = (rd_state_q == R_BURST) && (rd_rem_q != 9'd0) && can_load;

  always_comb begin
    wr_state_d    = wr_state_q;
    wr_idx_d      = wr_idx_q;
    wr_cnt_d      = wr_cnt_q;
    wr_err_d      = wr_err_q;
    wr_last_err_d = wr_last_err_q;
    case (wr_state_q)
      W_IDLE: if (aw_hs) begin
        wr_state_d    = W_DATA;
        wr_idx_d      = word_idx(user_axi_dma_awaddr);
        wr_cnt_d      = {1'b0, user_axi_dma_awlen} + 9'd1;
        wr_err_d      = burst_err(user_axi_dma_awaddr, user_axi_dma_awsize);
        wr_last_err_d = 1'b0;
      end
      W_DATA: if (w_hs) begin
        wr_idx_d = wr_idx_q + 1'b1;
        wr_cnt_d = wr_cnt_q - 9'd1;
        // beat count alone ends the burst; a misplaced wlast only poisons the response
        if (user_axi_dma_wlast != (wr_cnt_q == 9'd1)) wr_last_err_d = 1'b1;
        if (wr_cnt_q == 9'd1) wr_state_d = W_RESP;
      end
      W_RESP: if (b_hs) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = (wr_state_d == W_IDLE);
    wready_d  = (wr_state_d == W_DATA);
    bvalid_d  = (wr_state_d == W_RESP);
    bresp_d   = (bvalid_d && (wr_err_d || wr_last_err_d)) ? RESP_SLVERR : RESP_OKAY;
  end

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_idx_d     = rd_idx_q;
    rd_rem_d     = rd_rem_q;
    rd_err_d     = rd_err_q;
    fetch_d      = fetch_q;
    fetch_last_d = fetch_last_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    case (rd_state_q)
      R_IDLE: if (ar_hs) begin
        rd_state_d = R_BURST;
        rd_idx_d   = word_idx(user_axi_dma_araddr);
        rd_rem_d   = {1'b0, user_axi_dma_arlen} + 9'd1;
        rd_err_d   = burst_err(user_axi_dma_araddr, user_axi_dma_arsize);
      end
      R_BURST: begin
        if (mem_en) begin
          rd_idx_d = rd_idx_q + 1'b1;
          rd_rem_d = rd_rem_q - 9'd1;
        end
        if (r_hs && rlast_q) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    // RAM output register acts as the holding stage while the R register is stalled
    if (can_load) begin
      fetch_d  = mem_en;
      rvalid_d = fetch_q;
      rlast_d  = fetch_q && fetch_last_q;
      rresp_d  = (fetch_q && rd_err_q) ? RESP_SLVERR : RESP_OKAY;
      rdata_d  = (fetch_q && !rd_err_q) ? ram_rd_data : '0;
    end
    if (mem_en) fetch_last_d = (rd_rem_q == 9'd1);
    arready_d = (rd_state_d == R_IDLE);
  end

  always_ff @(posedge user_axi_clk) begin
    if (user_axi_rst) begin
      wr_state_q    <= W_IDLE;
      wr_idx_q      <= '0;
      wr_cnt_q      <= '0;
      wr_err_q      <= 1'b0;
      wr_last_err_q <= 1'b0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      rd_state_q    <= R_IDLE;
      rd_idx_q      <= '0;
      rd_rem_q      <= '0;
      rd_err_q      <= 1'b0;
      fetch_q       <= 1'b0;
      fetch_last_q  <= 1'b0;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      rresp_q       <= RESP_OKAY;
      rdata_q       <= '0;
    end else begin
      wr_state_q    <= wr_state_d;
      wr_idx_q      <= wr_idx_d;
      wr_cnt_q      <= wr_cnt_d;
      wr_err_q      <= wr_err_d;
      wr_last_err_q <= wr_last_err_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rd_state_q    <= rd_state_d;
      rd_idx_q      <= rd_idx_d;
      rd_rem_q      <= rd_rem_d;
      rd_err_q      <= rd_err_d;
      fetch_q       <= fetch_d;
      fetch_last_q  <= fetch_last_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rlast_q       <= rlast_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
    end
  end

  user_axi_dma_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (MEM_WORDS_LOG2)
  ) u_ram (
    .clk     (user_axi_clk),
    .wr_en   (w_hs && !wr_err_q),
    .wr_addr (wr_idx_q),
    .wr_data (user_axi_dma_wdata),
    .wr_strb (user_axi_dma_wstrb),
    .mem_en  (mem_en),
    .rd_addr (rd_idx_q),
    .rd_data (ram_rd_data)
  );

  assign user_axi_dma_awready = awready_q;
  assign user_axi_dma_wready  = wready_q;
  assign user_axi_dma_bvalid  = bvalid_q;
  assign user_axi_dma_bresp   = bresp_q;
  assign user_axi_dma_arready = arready_q;
  assign user_axi_dma_rvalid  = rvalid_q;
  assign user_axi_dma_rlast   = rlast_q;
  assign user_axi_dma_rresp   = rresp_q;
  assign user_axi_dma_rdata   = rdata_q;

endmodule

// File: tb/tb_user_axi_dma_mem_responder.sv
// Directed bench for user_axi_dma_mem_responder: burst vector table plus reset and reset-recovery sequences.
module tb_user_axi_dma_mem_responder;

  localparam int DW  = 128;
  localparam int AW  = 64;
  localparam int MWL = 10;
  localparam int NB  = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic          awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  user_axi_dma_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS_LOG2(MWL), .BASE_ADDR('0)
  ) dut (
    .user_axi_clk(clk), .user_axi_rst(rst),
    .user_axi_dma_awaddr(awaddr), .user_axi_dma_awlen(awlen), .user_axi_dma_awsize(awsize),
    .user_axi_dma_awvalid(awvalid), .user_axi_dma_awready(awready),
    .user_axi_dma_wdata(wdata), .user_axi_dma_wstrb(wstrb), .user_axi_dma_wlast(wlast),
    .user_axi_dma_wvalid(wvalid), .user_axi_dma_wready(wready),
    .user_axi_dma_bresp(bresp), .user_axi_dma_bvalid(bvalid), .user_axi_dma_bready(bready),
    .user_axi_dma_araddr(araddr), .user_axi_dma_arlen(arlen), .user_axi_dma_arsize(arsize),
    .user_axi_dma_arvalid(arvalid), .user_axi_dma_arready(arready),
    .user_axi_dma_rdata(rdata), .user_axi_dma_rresp(rresp), .user_axi_dma_rlast(rlast),
    .user_axi_dma_rvalid(rvalid), .user_axi_dma_rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [15:0] strb;
    logic [7:0]  seed;
    bit          fill;
    int          last_at;
    bit          do_wr;
    bit          do_rd;
    bit          mem_wr;
    logic [1:0]  exp_resp;
    int          rr_mode;
  } vec_t;

  vec_t          vecs [10];
  logic [DW-1:0] model [1024];
  int            n_checks = 0;
  int            n_err    = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  function automatic vec_t mk(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                              input logic [15:0] st, input logic [7:0] sd, input bit fl,
                              input int la, input bit wr, input bit rd, input bit mw,
                              input logic [1:0] er, input int rr);
    vec_t v;
    v.addr = a; v.len = l; v.size = s; v.strb = st; v.seed = sd; v.fill = fl;
    v.last_at = la; v.do_wr = wr; v.do_rd = rd; v.mem_wr = mw; v.exp_resp = er; v.rr_mode = rr;
    return v;
  endfunction

  function automatic logic [DW-1:0] beat_data(input vec_t v, input int b);
    logic [DW-1:0] d;
    logic [7:0]    base;
    base = 8'(v.seed * (b + 1));
    for (int j = 0; j < NB; j++) d[j*8 +: 8] = v.fill ? base : 8'(base + j);
    return d;
  endfunction

  task automatic do_write(input vec_t v);
    int            guard;
    int            idx;
    logic [DW-1:0] d;
    awaddr = v.addr; awlen = v.len; awsize = v.size; awvalid = 1;
    guard = 0;
    while (!awready && guard < 50) begin @(negedge clk); guard++; end
    if (!awready) begin timeout("aw_handshake"); awvalid = 0; return; end
    @(negedge clk);
    awvalid = 0;
    for (int b = 0; b <= int'(v.len); b++) begin
      d = beat_data(v, b);
      wdata = d; wstrb = v.strb; wlast = (b == v.last_at); wvalid = 1;
      guard = 0;
      while (!wready && guard < 50) begin @(negedge clk); guard++; end
      if (!wready) begin timeout("w_handshake"); wvalid = 0; wlast = 0; return; end
      @(negedge clk);
      if (v.mem_wr) begin
        idx = (int'(v.addr >> 4) + b) % 1024;
        for (int j = 0; j < NB; j++) if (v.strb[j]) model[idx][j*8 +: 8] = d[j*8 +: 8];
      end
      if (b < int'(v.len)) chk("bvalid_early", bvalid, 0);
    end
    wvalid = 0; wlast = 0;
    chk("bvalid_after_last_beat", bvalid, 1);
    chk("bresp", bresp, v.exp_resp);
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("bvalid_clear", bvalid, 0);
  endtask

  task automatic do_read(input vec_t v);
    int            guard, k, beat, first_k, last_k, idx;
    logic          stalled;
    logic [DW-1:0] held, exp_d;
    araddr = v.addr; arlen = v.len; arsize = v.size; arvalid = 1;
    guard = 0;
    while (!arready && guard < 50) begin @(negedge clk); guard++; end
    if (!arready) begin timeout("ar_handshake"); arvalid = 0; return; end
    @(negedge clk);
    arvalid = 0;
    k = 0; beat = 0; first_k = -1; last_k = 0; stalled = 0; held = '0;
    while (beat <= int'(v.len) && k < 4 * int'(v.len) + 40) begin
      rready = (v.rr_mode == 0) ? 1'b1 : (k % 2 == 1);
      if (rvalid) begin
        if (first_k < 0) begin
          first_k = k;
          chk("first_rvalid_latency", k, 2);
        end
        if (stalled) chk("rdata_stable_in_stall", rdata, held);
        if (rready) begin
          idx   = (int'(v.addr >> 4) + beat) % 1024;
          exp_d = (v.exp_resp != 2'b00) ? '0 : model[idx];
          chk("rdata", rdata, exp_d);
          chk("rresp", rresp, v.exp_resp);
          chk("rlast", rlast, beat == int'(v.len));
          beat++;
          last_k  = k;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = rdata;
        end
      end
      @(negedge clk);
      k++;
    end
    rready = 0;
    if (beat <= int'(v.len)) timeout("r_burst");
    else begin
      chk("rvalid_after_last", rvalid, 0);
      if (v.rr_mode == 0) chk("beats_back_to_back", last_k - first_k, v.len);
    end
  endtask

  initial begin
    int guard;
    vecs[0] = mk(64'h0,    8'd3,   3'd4, 16'hFFFF, 8'h11, 1, 3,   1, 1, 1, 2'b00, 0);
    vecs[1] = mk(64'h0,    8'd255, 3'd4, 16'hFFFF, 8'h01, 0, 255, 1, 1, 1, 2'b00, 0);
    vecs[2] = mk(64'h3FF0, 8'd1,   3'd4, 16'hFFFF, 8'h55, 0, 1,   1, 1, 1, 2'b00, 1);
    vecs[3] = mk(64'h4000, 8'd1,   3'd4, 16'hFFFF, 8'h77, 0, 1,   1, 1, 0, 2'b10, 0);
    vecs[4] = mk(64'h0,    8'd7,   3'd4, 16'h0000, 8'h00, 0, 7,   0, 1, 0, 2'b00, 1);
    vecs[5] = mk(64'h100,  8'd0,   3'd3, 16'hFFFF, 8'h99, 0, 0,   1, 1, 0, 2'b10, 0);
    vecs[6] = mk(64'h105,  8'd0,   3'd4, 16'hFFFF, 8'h66, 0, 0,   1, 1, 1, 2'b00, 0);
    vecs[7] = mk(64'h200,  8'd0,   3'd4, 16'hFFFF, 8'hFF, 1, 0,   1, 1, 1, 2'b00, 0);
    vecs[8] = mk(64'h200,  8'd0,   3'd4, 16'h0001, 8'h00, 1, 0,   1, 1, 1, 2'b00, 0);
    vecs[9] = mk(64'h300,  8'd2,   3'd4, 16'hFFFF, 8'h33, 0, 1,   1, 0, 0, 2'b10, 0);

    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, '0);
    rst = 0;
    @(negedge clk);
    chk("awready_after_rst", awready, 1);
    chk("arready_after_rst", arready, 1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) do_write(vecs[i]);
      if (vecs[i].do_rd) do_read(vecs[i]);
    end

    araddr = '0; arlen = 8'd15; arsize = 3'd4; arvalid = 1; rready = 1;
    guard = 0;
    while (!arready && guard < 50) begin @(negedge clk); guard++; end
    if (!arready) timeout("ar_before_reset");
    @(negedge clk);
    arvalid = 0;
    repeat (4) @(negedge clk);
    chk("rvalid_before_reset", rvalid, 1);
    rst = 1;
    @(negedge clk);
    chk("rvalid_in_reset", rvalid, 0);
    chk("arready_in_reset", arready, 0);
    chk("rlast_in_reset", rlast, 0);
    rst = 0; rready = 0;
    @(negedge clk);
    chk("arready_after_midburst_rst", arready, 1);
    chk("rvalid_after_midburst_rst", rvalid, 0);
    do_read(mk(64'h10, 8'd3, 3'd4, 16'h0, 8'h0, 0, 3, 0, 1, 0, 2'b00, 0));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
